// File: rtl/sl_pkg.sv
// Shared definitions for the SL transmitter scheduler: states, register field
// positions, legality limits and the config word builder.
package sl_pkg;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned LEN_W    = 6;
   localparam int unsigned FREQ_W   = 3;
   localparam int unsigned LEN_LSB  = 0;
   localparam int unsigned FREQ_LSB = 7;
   localparam int unsigned BUSY_BIT = 16;
   localparam int unsigned LEN_MIN  = 8;
   localparam int unsigned LEN_MAX  = 32;
   localparam int unsigned FREQ_MAX = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_CFG,
      S_DATA,
      S_SETTLE,
      S_WAIT,
      S_DONE
   } sl_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [LEN_W-1:0]  len;
      logic [FREQ_W-1:0] freq;
   } sl_req_t;

   function automatic logic [DATA_W-1:0] cfg_word(input logic [FREQ_W-1:0] freq,
                                                  input logic [LEN_W-1:0]  len);
      logic [DATA_W-1:0] w;
      w = '0;
      w[FREQ_LSB +: FREQ_W] = freq;
      w[LEN_LSB +: LEN_W]   = len;
      return w;
   endfunction

   // Even length within [LEN_MIN, LEN_MAX] and a supported frequency mode
   function automatic logic req_legal(input sl_req_t r);
      return !r.len[0] &&
             (r.len >= LEN_W'(LEN_MIN)) &&
             (r.len <= LEN_W'(LEN_MAX)) &&
             (r.freq <= FREQ_W'(FREQ_MAX));
   endfunction

endpackage

// File: rtl/sl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around.
module sl_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx
);

   logic found;

   // Upper pass covers ptr..N_REQ-1, lower pass wraps to 0..ptr-1
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req[k] && (IW'(k) >= ptr)) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req[k] && (IW'(k) < ptr)) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/sl_tx_scheduler.sv
// Shares one SL transmitter between N_REQ word requesters: round-robin grant,
// optional config write, data write, then busy polling until the word is out.
module sl_tx_scheduler
   import sl_pkg::*;
#(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned SETTLE = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [DATA_W*N_REQ-1:0]    req_data,
   input  logic [LEN_W*N_REQ-1:0]     req_len,
   input  logic [FREQ_W*N_REQ-1:0]    req_freq,
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           req_done,
   output logic [N_REQ-1:0]           req_err,
   output logic [DATA_W-1:0]          tx_d_in,
   output logic                       tx_wr_en,
   output logic                       tx_addr,
   input  logic [DATA_W-1:0]          tx_d_out,
   output logic                       sched_busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id
);

   localparam int unsigned IW      = $clog2(N_REQ);
   localparam int unsigned CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned CACHE_W = FREQ_W + LEN_W;

   sl_state_t            state_q, state_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]        settle_q, settle_d;
   sl_req_t              req_q, req_d, sel_req;
   logic                 cache_vld_q, cache_vld_d;
   logic [CACHE_W-1:0]   cache_q, cache_d;
   logic                 err_pend_q, err_pend_d;

   logic [N_REQ-1:0]     ready_d, done_d, err_d;
   logic [DATA_W-1:0]    tx_d_in_d;
   logic                 tx_wr_en_d, tx_addr_d, sched_busy_d;
   logic [IW-1:0]        grant_id_d;

   logic [N_REQ-1:0]     arb_gnt;
   logic [IW-1:0]        arb_idx;
   logic                 tx_busy;
   logic                 unused_d_out;

   assign tx_busy      = tx_d_out[BUSY_BIT];
   assign unused_d_out = ^{tx_d_out[DATA_W-1:BUSY_BIT+1], tx_d_out[BUSY_BIT-1:0]};

   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      return (p == IW'(N_REQ - 1)) ? '0 : p + IW'(1);
   endfunction

   sl_rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_arb (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Mux out the granted requester's payload
   always_comb begin
      sel_req = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_gnt[i]) begin
            sel_req.data = req_data[i*DATA_W +: DATA_W];
            sel_req.len  = req_len[i*LEN_W +: LEN_W];
            sel_req.freq = req_freq[i*FREQ_W +: FREQ_W];
         end
      end
   end

   // Next state, plus registered outputs decoded from the state being entered
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      settle_d     = settle_q;
      req_d        = req_q;
      cache_vld_d  = cache_vld_q;
      cache_d      = cache_q;
      err_pend_d   = 1'b0;
      ready_d      = '0;
      done_d       = '0;
      err_d        = '0;
      tx_d_in_d    = '0;
      tx_wr_en_d   = 1'b0;
      tx_addr_d    = 1'b0;
      grant_id_d   = grant_id;

      if (err_pend_q) err_d[grant_id] = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (|req_valid) state_d = S_ARB;
         end
         S_ARB: begin
            if (|req_valid) begin
               ready_d    = arb_gnt;
               grant_id_d = arb_idx;
               req_d      = sel_req;
               if (!req_legal(sel_req)) begin
                  err_pend_d = 1'b1;
                  rr_ptr_d   = ptr_inc(arb_idx);
                  state_d    = S_IDLE;
               end else if (cache_vld_q && (cache_q == {sel_req.freq, sel_req.len})) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_CFG;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CFG: begin
            cache_vld_d = 1'b1;
            cache_d     = {req_q.freq, req_q.len};
            state_d     = S_DATA;
         end
         S_DATA: begin
            settle_d = CW'(SETTLE - 1);
            state_d  = (SETTLE == 0) ? S_WAIT : S_SETTLE;
         end
         S_SETTLE: begin
            if (settle_q == '0) state_d = S_WAIT;
            else                settle_d = settle_q - CW'(1);
         end
         S_WAIT: begin
            if (!tx_busy) state_d = S_DONE;
         end
         S_DONE: begin
            rr_ptr_d = ptr_inc(grant_id);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      unique case (state_d)
         S_CFG: begin
            tx_addr_d  = 1'b1;
            tx_wr_en_d = 1'b1;
            tx_d_in_d  = cfg_word(req_d.freq, req_d.len);
         end
         S_DATA: begin
            tx_wr_en_d = 1'b1;
            tx_d_in_d  = req_d.data;
         end
         S_SETTLE, S_WAIT: tx_addr_d = 1'b1;
         S_DONE:           done_d[grant_id_d] = 1'b1;
         default: ;
      endcase

      sched_busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         settle_q    <= '0;
         req_q       <= '0;
         cache_vld_q <= 1'b0;
         cache_q     <= '0;
         err_pend_q  <= 1'b0;
         req_ready   <= '0;
         req_done    <= '0;
         req_err     <= '0;
         tx_d_in     <= '0;
         tx_wr_en    <= 1'b0;
         tx_addr     <= 1'b0;
         sched_busy  <= 1'b0;
         grant_id    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         settle_q    <= settle_d;
         req_q       <= req_d;
         cache_vld_q <= cache_vld_d;
         cache_q     <= cache_d;
         err_pend_q  <= err_pend_d;
         req_ready   <= ready_d;
         req_done    <= done_d;
         req_err     <= err_d;
         tx_d_in     <= tx_d_in_d;
         tx_wr_en    <= tx_wr_en_d;
         tx_addr     <= tx_addr_d;
         sched_busy  <= sched_busy_d;
         grant_id    <= grant_id_d;
      end
   end

endmodule

// File: doc/sl_tx_scheduler.md
# sl_tx_scheduler

Shares one SL transmitter between `N_REQ` word requesters. Each requester offers a data word, length and frequency mode. The scheduler grants requesters round-robin and drives the transmitter's register port: config write at addr 1, data write at addr 0, then a poll of the busy flag until the word has left the SL0/SL1 lines. It sits between the host-side word sources and the transmitter, and it is the only master on the transmitter's `d_in`/`wr_en`/`addr` port.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `SETTLE`, 2, cycles between the data write and the first busy sample
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  N_REQ  requester i has a word pending
- `req_data`  in  32*N_REQ  word for requester i, slice [32i+31:32i]
- `req_len`  in  6*N_REQ  bit length for requester i
- `req_freq`  in  3*N_REQ  frequency mode for requester i
- `req_ready`  out  N_REQ  one-cycle accept strobe, one-hot
- `req_done`  out  N_REQ  one-cycle pulse when requester i's word has finished transmitting
- `req_err`  out  N_REQ  one-cycle pulse when a request is rejected
- `tx_d_in`  out  32  to transmitter `d_in`
- `tx_wr_en`  out  1  to transmitter `wr_en`
- `tx_addr`  out  1  to transmitter `addr`
- `tx_d_out`  in  32  from transmitter `d_out`; bit 16 = busy when `tx_addr`=1
- `sched_busy`  out  1  scheduler not in IDLE
- `grant_id`  out  $clog2(N_REQ)  index of the current or last grant

## Operation
- FSM states: IDLE, ARB, CFG, DATA, SETTLE, WAIT, DONE.
- **IDLE**: if `req_valid` is nonzero, go to ARB.
- **ARB**: round-robin pick, starting at `rr_ptr`, of the first valid requester.
  - Pulse `req_ready[i]`.
  - Latch data, len and freq into local registers, since the requester may change its inputs after the accept.
  - If len is illegal, pulse `req_err[i]` in the next cycle, advance `rr_ptr`, and return to IDLE with no transmitter access. Illegal means odd, <8, or >32, or freq >5.
  - Otherwise go to CFG. If the config cache is valid and equal to {freq,len}, go straight to DATA.
- **CFG**: for one cycle, `tx_addr`=1, `tx_wr_en`=1, `tx_d_in`={22'b0, freq[2:0], 1'b0, len[5:0]}. Update the cache and set it valid. Go to DATA.
- **DATA**: for one cycle, `tx_addr`=0, `tx_wr_en`=1, `tx_d_in`=data. Go to SETTLE.
- **SETTLE**: hold `tx_addr`=1 and `tx_wr_en`=0 for `SETTLE` cycles. Go to WAIT.
- **WAIT**: hold `tx_addr`=1. The first cycle with `tx_d_out[16]`=0 goes to DONE. There is no timeout.
- **DONE**: pulse `req_done[grant_id]`, set `rr_ptr`=grant_id+1 mod N_REQ, go to IDLE.
- `tx_d_in`=0 and `tx_wr_en`=0 in every state except CFG and DATA.
- `tx_addr`=0 in IDLE, ARB, DATA and DONE.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `rr_ptr`=0, cache invalid.
- Accept latency: `req_ready` is asserted in the second cycle after `req_valid` rises while the scheduler is idle (IDLE→ARB).
- Minimum turnaround, valid to data write, with CFG: ARB, CFG, DATA = data write on cycle 3 after leaving IDLE. With a cache hit, the data write is on cycle 2.
- `req_valid` may drop at any time before `req_ready`. The arbiter samples it only in ARB.
- Simultaneous requests: exactly one `req_ready` per arbitration. A requester that stays valid is served again only after all other valid requesters have had a turn.
- `req_done` and `req_err` never share a cycle with any `req_ready`.
- Reset mid-transfer:
  - All state clears asynchronously and the cache is invalidated.
  - The in-flight word gets no `req_done`.
  - The transmitter shares `rst_n`, so it is also reset.
- `grant_id` is updated in ARB and holds until the next ARB.

## Structure
- Shared package `sl_pkg`:
  - State enum.
  - Config field positions: LEN [5:0], FREQ [9:7].
  - Status bit BUSY_BIT=16.
  - Constants LEN_MIN=8, LEN_MAX=32, FREQ_MAX=5.
  - Function `cfg_word(freq, len)`.
- One sub-module, `sl_rr_arbiter`: parameterised on N_REQ; inputs request vector and pointer; outputs one-hot grant and index. It is purely combinational.

## Test plan
- Single request: req 0, len=16, freq=2, data=0x0000A5C3 → CFG write 0x00000110, then DATA write 0x0000A5C3. The ideal receiver gets 16 bits with value 0xA5C3 and valid parity. `req_done[0]` pulses once.
- Cache hit: same len and freq again on req 1 → no addr-1 write occurs; data goes out; `req_done[1]` pulses.
- Contention: all 4 requests held valid from reset → grant order 0,1,2,3,0. Each `req_done` precedes the next `req_ready`.
- Illegal request: len=7 on req 2 → `req_err[2]` pulses, no `tx_wr_en` pulse, `rr_ptr`=3.
- Busy hold: the transmitter holds busy for 400 cycles → the scheduler stays in WAIT with `tx_addr`=1 and issues no writes. `req_done` pulses 1 cycle after busy falls.
- Reset mid-WAIT: drive `rst_n`=0 → all outputs go to 0 immediately. After release, a fresh request gets a CFG write, because the cache was invalidated.
